// File: rtl/br_resolve_if.sv
// Issue and CDB handshake channels of the branch resolution unit.
// The master side issues branches and consumes CDB writebacks. The slave side is the resolver.
interface br_resolve_if #(
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4
);
    logic                 in_req;
    logic [3:0]           in_opc;
    logic [31:0]          in_src1;
    logic [31:0]          in_src2;
    logic [31:0]          in_pc;
    logic [11:0]          in_offset;
    logic                 in_pred_taken;
    logic [31:0]          in_pred_pc;
    logic [TAG_W-1:0]     in_tag;
    logic [ROB_PTR_W-1:0] in_rob_id;
    logic                 in_rdy;

    logic                 cdb_req;
    logic [TAG_W-1:0]     cdb_tag;
    logic [31:0]          cdb_wdata;
    logic [ROB_PTR_W-1:0] cdb_rob_id;
    logic                 cdb_rdy;

    modport master (
        output in_req, in_opc, in_src1, in_src2, in_pc, in_offset,
               in_pred_taken, in_pred_pc, in_tag, in_rob_id,
        input  in_rdy,
        input  cdb_req, cdb_tag, cdb_wdata, cdb_rob_id,
        output cdb_rdy
    );

    modport slave (
        input  in_req, in_opc, in_src1, in_src2, in_pc, in_offset,
               in_pred_taken, in_pred_pc, in_tag, in_rob_id,
        output in_rdy,
        output cdb_req, cdb_tag, cdb_wdata, cdb_rob_id,
        input  cdb_rdy
    );
endinterface

// File: rtl/br_resolve.sv
// Branch resolution unit. It resolves branches and jumps at issue, writes the link value on the CDB,
// and holds the in-flight outcomes in order until commit. A mispredicted outcome redirects the front end.
module br_resolve #(
    parameter  int TAG_W     = 4,
    parameter  int ROB_DEPTH = 16,
    parameter  int DEPTH     = 4,
    parameter  int CNT_W     = 16,
    localparam int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    br_resolve_if.slave          bus,
    input  logic                 commit_vld,
    input  logic [ROB_PTR_W-1:0] commit_rob_id,
    input  logic                 flush_in,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [CNT_W-1:0]     mispred_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [3:0] {
        OP_BEQ  = 4'd0,
        OP_BNE  = 4'd1,
        OP_BLT  = 4'd4,
        OP_BGE  = 4'd5,
        OP_BLTU = 4'd6,
        OP_BGEU = 4'd7,
        OP_JAL  = 4'd8,
        OP_JALR = 4'd9
    } op_e;

    typedef struct packed {
        logic [ROB_PTR_W-1:0] rob_id;
        logic [31:0]          next_pc;
        logic                 mispred;
    } entry_t;

    entry_t       q_mem [DEPTH];
    logic [PTR_W:0] head;
    logic [PTR_W:0] tail;
    entry_t       head_entry;
    logic         empty;
    logic         full;
    logic         accept;
    logic         pop;
    logic         clear_all;

    logic         taken;
    logic [31:0]  target;
    logic [31:0]  br_target;
    logic [31:0]  jmp_sum;
    logic [31:0]  next_pc;
    logic         mispred;

    // Resolution happens entirely at issue; only the outcome is kept for commit.
    assign br_target = bus.in_pc + {{19{bus.in_offset[11]}}, bus.in_offset, 1'b0};
    assign jmp_sum   = bus.in_src1 + bus.in_src2;

    always_comb begin
        taken  = 1'b1;
        target = jmp_sum;
        case (bus.in_opc)
            OP_BEQ:  begin taken = (bus.in_src1 == bus.in_src2);                   target = br_target; end
            OP_BNE:  begin taken = (bus.in_src1 != bus.in_src2);                   target = br_target; end
            OP_BLT:  begin taken = ($signed(bus.in_src1) <  $signed(bus.in_src2)); target = br_target; end
            OP_BGE:  begin taken = ($signed(bus.in_src1) >= $signed(bus.in_src2)); target = br_target; end
            OP_BLTU: begin taken = (bus.in_src1 <  bus.in_src2);                   target = br_target; end
            OP_BGEU: begin taken = (bus.in_src1 >= bus.in_src2);                   target = br_target; end
            OP_JALR: target = {jmp_sum[31:1], 1'b0};
            default: ;
        endcase
    end

    assign next_pc = taken ? target : bus.in_pc + 32'd4;
    assign mispred = (taken != bus.in_pred_taken) | (taken & (target != bus.in_pred_pc));

    assign head_entry = q_mem[head[PTR_W-1:0]];
    assign empty      = (head == tail);
    assign full       = (head[PTR_W-1:0] == tail[PTR_W-1:0]) & (head[PTR_W] != tail[PTR_W]);

    assign pop         = ~empty & commit_vld & (commit_rob_id == head_entry.rob_id) & ~flush_in;
    assign redirect    = pop & head_entry.mispred;
    assign redirect_pc = empty ? 32'd0 : head_entry.next_pc;
    assign clear_all   = flush_in | redirect;

    assign bus.in_rdy = ~full & (~bus.cdb_req | bus.cdb_rdy) & ~flush_in & ~redirect;
    assign accept     = bus.in_req & bus.in_rdy;

    // NOTE: sequential state uses non-blocking assignments so that every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else if (clear_all) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (accept) tail <= tail + 1'b1;
            if (pop)    head <= head + 1'b1;
        end
    end

    // NOTE: the entry storage has no reset. The pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (accept) q_mem[tail[PTR_W-1:0]] <= '{rob_id: bus.in_rob_id, next_pc: next_pc, mispred: mispred};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cdb_req    <= 1'b0;
            bus.cdb_tag    <= '0;
            bus.cdb_wdata  <= '0;
            bus.cdb_rob_id <= '0;
        end else if (clear_all) begin
            bus.cdb_req <= 1'b0;
        end else if (accept) begin
            bus.cdb_req    <= 1'b1;
            bus.cdb_tag    <= bus.in_tag;
            bus.cdb_wdata  <= bus.in_pc + 32'd4;
            bus.cdb_rob_id <= bus.in_rob_id;
        end else if (bus.cdb_req && bus.cdb_rdy) begin
            bus.cdb_req <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispred_cnt <= '0;
        end else if (redirect && (mispred_cnt != {CNT_W{1'b1}})) begin
            mispred_cnt <= mispred_cnt + 1'b1;
        end
    end
endmodule
